// File: rtl/udp_ipv4_tx.sv
// udp_ipv4_tx: prepends a 20-byte IPv4 header and an 8-byte UDP header to an
// application payload stream and forwards the frame to the MAC transmitter.
// Optional build macro: UDP_IPV4_TX_ID_INC_EN enables a per-datagram IPv4
// identification counter; without it the identification field is 0x0000.
module udp_ipv4_tx #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned LEN_W       = $clog2(DATA_W / 8 + 1),
    parameter logic [31:0] IP_SRC_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [31:0] IP_DST_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [15:0] SRC_PORT    = 16'd18070,
    parameter logic [15:0] DST_PORT    = 16'd18070,
    parameter logic [7:0]  TTL         = 8'd64,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              app_valid_i,
    input  logic              app_start_i,
    input  logic              app_term_i,
    input  logic [DATA_W-1:0] app_data_i,
    input  logic [LEN_W-1:0]  app_len_i,
    input  logic [15:0]       app_pkt_len_i,
    output logic              app_ready_o,
    output logic              err_o,
    input  logic              mac_ready_i,
    output logic              mac_valid_o,
    output logic              mac_start_o,
    output logic              mac_term_o,
    output logic              mac_cancel_o,
    output logic [DATA_W-1:0] mac_data_o,
    output logic [LEN_W-1:0]  mac_len_o
);

    if (DATA_W != 16) begin : g_bad_width
        $error("udp_ipv4_tx supports DATA_W == 16 only");
    end

    typedef enum logic [2:0] {StIdle, StCsum, StHdr, StPayload, StDrain, StDrop} state_e;

    // Constant header words pre-summed and folded at elaboration time.
    localparam logic [31:0] KSum = 32'h4500 + 32'h4000 + {16'h0000, TTL, 8'd17}
                                 + {16'h0000, IP_SRC_ADDR[31:16]} + {16'h0000, IP_SRC_ADDR[15:0]}
                                 + {16'h0000, IP_DST_ADDR[31:16]} + {16'h0000, IP_DST_ADDR[15:0]};
    localparam logic [31:0] KF1  = {16'h0000, KSum[15:0]} + {16'h0000, KSum[31:16]};
    localparam logic [31:0] KF2  = {16'h0000, KF1[15:0]} + {16'h0000, KF1[31:16]};
    localparam logic [15:0] K16  = KF2[15:0];

    state_e            state_q, state_d;
    logic [15:0]       pkt_len_q, pkt_len_d;
    logic [15:0]       csum_q, csum_d;
    logic [3:0]        word_q, word_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d, start_q, start_d, term_q, term_d, cancel_q, cancel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [15:0]       id_val;
    logic              out_en;
    logic [15:0]       total_len, udp_len, hdr_word;
    logic [17:0]       sum18;
    logic [16:0]       fold1, cnt_next;
    logic [15:0]       fold2;

`ifdef UDP_IPV4_TX_ID_INC_EN
    logic [15:0] id_q;
    logic        id_inc;

    // A datagram leaves the encapsulator when its terminating beat is accepted.
    assign id_inc = app_valid_i && app_term_i
                 && ((state_q == StPayload && out_en) || state_q == StDrain);
    assign id_val = id_q;

    // Identification counter, wraps 0xFFFF -> 0x0000.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            id_q <= 16'h0000;
        end else if (id_inc) begin
            id_q <= id_q + 16'd1;
        end
    end
`else
    assign id_val = 16'h0000;
`endif

    assign out_en    = !valid_q || mac_ready_i;
    assign total_len = pkt_len_q + 16'd28;
    assign udp_len   = pkt_len_q + 16'd8;
    assign sum18     = {2'b00, K16} + {2'b00, total_len} + {2'b00, id_val};
    assign fold1     = {1'b0, sum18[15:0]} + {15'h0000, sum18[17:16]};
    assign fold2     = fold1[15:0] + {15'h0000, fold1[16]};
    assign cnt_next  = {1'b0, byte_cnt_q} + 17'(app_len_i);

    // Header word selected by the word counter.
    always_comb begin
        hdr_word = 16'h0000;
        case (word_q)
            4'd0:    hdr_word = 16'h4500;
            4'd1:    hdr_word = total_len;
            4'd2:    hdr_word = id_val;
            4'd3:    hdr_word = 16'h4000;
            4'd4:    hdr_word = {TTL, 8'd17};
            4'd5:    hdr_word = csum_q;
            4'd6:    hdr_word = IP_SRC_ADDR[31:16];
            4'd7:    hdr_word = IP_SRC_ADDR[15:0];
            4'd8:    hdr_word = IP_DST_ADDR[31:16];
            4'd9:    hdr_word = IP_DST_ADDR[15:0];
            4'd10:   hdr_word = SRC_PORT;
            4'd11:   hdr_word = DST_PORT;
            4'd12:   hdr_word = udp_len;
            default: hdr_word = 16'h0000;
        endcase
    end

    // Next-state, output-register load and handshake logic.
    always_comb begin
        state_d     = state_q;
        pkt_len_d   = pkt_len_q;
        csum_d      = csum_q;
        word_d      = word_q;
        byte_cnt_d  = byte_cnt_q;
        err_d       = 1'b0;
        valid_d     = valid_q;
        start_d     = start_q;
        term_d      = term_q;
        cancel_d    = cancel_q;
        data_d      = data_q;
        len_d       = len_q;
        app_ready_o = 1'b0;
        // A consumed (or empty) output register empties unless reloaded below.
        if (out_en) begin
            valid_d  = 1'b0;
            start_d  = 1'b0;
            term_d   = 1'b0;
            cancel_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                // The start beat is only peeked here; PAYLOAD or DROP consumes it.
                if (app_valid_i && app_start_i) begin
                    pkt_len_d = app_pkt_len_i;
                    if (app_pkt_len_i > MAX_PAYLOAD || app_pkt_len_i == 16'd0) begin
                        state_d = StDrop;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                csum_d  = ~fold2;
                word_d  = 4'd0;
                state_d = StHdr;
            end
            StHdr: begin
                if (out_en) begin
                    valid_d = 1'b1;
                    start_d = (word_q == 4'd0);
                    data_d  = {hdr_word[7:0], hdr_word[15:8]};
                    len_d   = LEN_W'(2);
                    word_d  = word_q + 4'd1;
                    if (word_q == 4'd13) begin
                        byte_cnt_d = 16'h0000;
                        state_d    = StPayload;
                    end
                end
            end
            StPayload: begin
                app_ready_o = out_en;
                if (app_valid_i && out_en) begin
                    valid_d    = 1'b1;
                    data_d     = app_data_i;
                    len_d      = app_len_i;
                    byte_cnt_d = cnt_next[15:0];
                    if (app_term_i) begin
                        term_d   = 1'b1;
                        cancel_d = (cnt_next != {1'b0, pkt_len_q});
                        state_d  = StIdle;
                    end else if (cnt_next > {1'b0, pkt_len_q}) begin
                        term_d   = 1'b1;
                        cancel_d = 1'b1;
                        state_d  = StDrain;
                    end
                end
            end
            StDrain, StDrop: begin
                app_ready_o = 1'b1;
                if (app_valid_i && app_term_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= StIdle;
            pkt_len_q  <= 16'h0000;
            csum_q     <= 16'h0000;
            word_q     <= 4'd0;
            byte_cnt_q <= 16'h0000;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            term_q     <= 1'b0;
            cancel_q   <= 1'b0;
            data_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            pkt_len_q  <= pkt_len_d;
            csum_q     <= csum_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            term_q     <= term_d;
            cancel_q   <= cancel_d;
            data_q     <= data_d;
            len_q      <= len_d;
        end
    end

    assign err_o        = err_q;
    assign mac_valid_o  = valid_q;
    assign mac_start_o  = start_q;
    assign mac_term_o   = term_q;
    assign mac_cancel_o = cancel_q;
    assign mac_data_o   = data_q;
    assign mac_len_o    = len_q;

endmodule

// File: doc/udp_ipv4_tx.md
Name: udp_ipv4_tx

Overview:
- Transmit-side transport/network encapsulator; the mirror of the UDP/IPv4 receive path.
- Takes an application payload stream plus its byte length and emits a 28-byte IPv4 header (20 B, no options) and UDP header (8 B), then the payload, as one stream toward the MAC transmitter.
- Computes the IPv4 header checksum on the fly. The UDP checksum is sent as 0x0000, which is legal for IPv4.
- Sits between the application and mac_tx.

Parameters:
- DATA_W, 16: datapath width in bits. Only 16 is supported in this revision; any other value fails elaboration.
- LEN_W, $clog2(DATA_W/8+1): width of byte-valid count.
- IP_SRC_ADDR, {8'd206,8'd200,8'd127,8'd128}: IPv4 source address.
- IP_DST_ADDR, {8'd206,8'd200,8'd127,8'd128}: IPv4 destination address.
- SRC_PORT, 16'd18070: UDP source port.
- DST_PORT, 16'd18070: UDP destination port.
- TTL, 8'd64: IPv4 time-to-live.
- MAX_PAYLOAD, 16'd1472: largest accepted UDP payload in bytes.

Ports:
- clk, in, 1: clock; single clock domain.
- nreset, in, 1: asynchronous, active-low reset.
- app_valid_i, in, 1: payload beat valid.
- app_start_i, in, 1: first payload beat of a datagram; qualifies app_pkt_len_i.
- app_term_i, in, 1: last payload beat.
- app_data_i, in, DATA_W: payload data, first byte in bits [7:0].
- app_len_i, in, LEN_W: valid bytes in the beat, 1..2.
- app_pkt_len_i, in, 16: UDP payload length in bytes; sampled with app_start_i.
- app_ready_o, out, 1: payload beat accepted this cycle.
- err_o, out, 1: one-cycle pulse, datagram dropped (oversize).
- mac_ready_i, in, 1: downstream accepts a beat.
- mac_valid_o, out, 1: output beat valid.
- mac_start_o, out, 1: first beat, i.e. header word 0.
- mac_term_o, out, 1: last beat.
- mac_cancel_o, out, 1: with mac_term_o, tells MAC to abort the frame.
- mac_data_o, out, DATA_W: output data.
- mac_len_o, out, LEN_W: valid bytes.

Behaviour:
- Reset: all outputs 0; state IDLE; IP identification counter 0.
- Output register handshake: the output register loads when !mac_valid_o || mac_ready_i. Data and controls stay stable while mac_valid_o && !mac_ready_i.
- IDLE:
  - app_ready_o=0.
  - On app_valid_i && app_start_i: latch app_pkt_len_i (the beat is not consumed).
  - If pkt_len > MAX_PAYLOAD or pkt_len == 0 -> DROP; else -> CSUM.
- CSUM (exactly 1 cycle):
  - checksum = ~fold(fold(K + total_len + id)), where K is the elaboration-time sum of the constant header words.
  - Constant header words: 0x4500, 0x4000, {TTL,8'd17}, source address halves, destination address halves.
  - total_len = 28 + pkt_len. Sum is held in 18 bits; two end-around-carry folds.
  - -> HDR.
- HDR:
  - 14 words emitted in network byte order, each word big-endian across the two bytes (byte0 = bits [7:0] = MSB of the field): 4500, total_len, id, 4000, {TTL,11}, checksum, src_hi, src_lo, dst_hi, dst_lo, SRC_PORT, DST_PORT, 8+pkt_len, 0000.
  - mac_len_o=2 on every header word; mac_start_o only on word 0.
  - A 4-bit word counter advances on each output load; after word 13 -> PAYLOAD.
- PAYLOAD:
  - app_ready_o = !mac_valid_o || mac_ready_i.
  - Accepted beats are registered to the output: 1 cycle latency, no bubbles.
  - A 16-bit byte counter accumulates app_len_i.
  - On an accepted app_term_i beat: mac_term_o=1, and mac_cancel_o=1 if the final count != pkt_len.
  - On a byte-count overrun without term: mac_term_o=1 and mac_cancel_o=1 on that beat, then ignore further beats until app_term_i is accepted (DRAIN).
  - After term -> IDLE; id increments (see Optional Feature), wrapping 0xFFFF->0x0000.
- DROP:
  - app_ready_o=1; consume beats through app_term_i; nothing emitted.
  - err_o pulses on entry.
  - -> IDLE; id unchanged.
- Back-to-back datagrams: a start in IDLE the cycle after returning is accepted. Minimum gap from the last payload beat to the next mac_start_o is 2 cycles.
- app_start_i seen in PAYLOAD: treated as an ordinary data beat (no restart).
- Reset mid-frame: immediate return to IDLE, outputs 0, no term emitted.

Optional Feature:
- Macro: UDP_IPV4_TX_ID_INC_EN.
- Defined: identification counter increments once per transmitted (not dropped) datagram.
- Undefined: the identification field is constant 0x0000. The counter is not instantiated and checksum uses id=0. DF is set in both cases.

Test Plan:
- Defaults, pkt_len=18, 9 beats, mac_ready_i=1:
  - header words 4500, 002E, 0000, 4000, 4011, 9E2D, CEC8, 7F80, CEC8, 7F80, 4696, 4696, 001A, 0000;
  - then 9 payload words; mac_term_o on payload beat 9; mac_cancel_o=0.
- pkt_len=3, beats len 2 then len 1 -> last beat mac_len_o=1, mac_term_o=1; total_len word 001F, UDP length 000B.
- Random mac_ready_i toggling (50%) over a 100-byte datagram -> output identical to the ready=1 run; data held stable while stalled.
- pkt_len=1473 -> err_o single pulse; all beats consumed; no mac_valid_o; next datagram id unchanged.
- pkt_len=10, app_term_i after 8 bytes -> mac_term_o=1 and mac_cancel_o=1 on the 8-byte beat. With the macro defined, id increments on the next datagram.
- id wrap, macro defined: preload by sending 65536 datagrams (or force) -> id 0xFFFF then 0x0000, checksum correct for both.
